board_mem_arbiter: RTL and testbench
====================================

// Module: board_mem_arbiter
// PURPOSE
//  Shares the single-port 256x1 mine-board memory among three requesters:
//  display read (DISP), mine placer read/write (PLACE) and neighbour counter read (CNT).
//  Also sequences a full-board clear before each new game.
//  Sits between the game FSM, mine_algorithm, neighbour counter, VGA renderer and the altsyncram board.
// PARAMETERS
//  ADDR_W     8    board address width
//  NUM_CELLS  256  cells swept by clear (<= 2**ADDR_W)
//  RD_LAT     1    memory read latency in clocks, mem_addr -> mem_q
// PORTS
//  clk          in   1       system clock
//  rst          in   1       reset, synchronous, active-high
//  clear_start  in   1       one-cycle pulse: start board clear
//  clear_busy   out  1       high while the clear sweep runs
//  clear_done   out  1       one-cycle pulse after the last clear write
//  d_req        in   1       DISP read request
//  d_addr       in   ADDR_W  DISP read address
//  d_gnt        out  1       DISP accepted this cycle
//  d_rvalid     out  1       DISP read data valid
//  p_req        in   1       PLACE request
//  p_we         in   1       PLACE: 1 = write, 0 = read
//  p_addr       in   ADDR_W  PLACE address
//  p_wdata      in   1       PLACE write data (1 = mine)
//  p_gnt        out  1       PLACE accepted this cycle
//  p_rvalid     out  1       PLACE read data valid (never set for writes)
//  c_req        in   1       CNT read request
//  c_addr       in   ADDR_W  CNT read address
//  c_gnt        out  1       CNT accepted this cycle
//  c_rvalid     out  1       CNT read data valid
//  rdata        out  1       shared read data; qualified by the *_rvalid strobes
//  mem_addr     out  ADDR_W  to memory, registered
//  mem_data     out  1       to memory, registered
//  mem_wren     out  1       to memory, registered
//  mem_q        in   1       from memory
// BEHAVIOUR
//  - Reset: state ARB; all gnt, rvalid, clear_busy and clear_done are 0; mem_addr = 0, mem_data = 0, mem_wren = 0.
//    The read-tag pipeline is flushed and the clear counter is 0.
//  - States:
//    - ARB: grants requests.
//    - CLEAR: sweeps the board.
//    - ARB -> CLEAR on clear_start. CLEAR -> ARB after the write to NUM_CELLS-1.
//  - Handshake: *_gnt is combinational, at most one per cycle, asserted only in ARB.
//    - A transfer occurs when req & gnt are high at a clock edge.
//    - Requester holds req/addr/we/wdata stable until granted. It may present the next request in the following cycle.
//  - Back-to-back grants are allowed; throughput is 1 access per clock.
//  - On the handshake edge: mem_addr <= addr, mem_wren <= (PLACE & p_we), mem_data <= p_wdata (else 0).
//    mem_wren is high for exactly one cycle per write.
//  - Read return: a 2-bit requester tag enters a (1+RD_LAT)-deep pipeline.
//    The matching *_rvalid pulses exactly 1+RD_LAT cycles after the handshake cycle, with rdata = mem_q.
//    Reads are returned in issue order.
//  - Default priority: DISP > PLACE > CNT (fixed).
//  - CLEAR:
//    - clear_busy is 1 from the cycle after clear_start.
//    - One write of 0 per clock to addresses 0..NUM_CELLS-1, i.e. NUM_CELLS cycles.
//    - No grants during the sweep.
//    - clear_done pulses on the cycle after the last write, with clear_busy = 0 in that same cycle.
//  - clear_start while in CLEAR is ignored.
//  - clear_start in the same cycle as a request: clear wins and no grant is given.
//    In-flight reads still return their rvalid.
//  - Address counter compare is exact. There is no wrap past NUM_CELLS-1.
//  - rst mid-clear aborts the sweep and returns to ARB. Board contents are then unspecified.
// CONFIGURATION
//  - ARB_ROUND_ROBIN_EN defined: rotating priority.
//    The requester granted last becomes lowest priority; the order is DISP->PLACE->CNT->DISP.
//    After reset the pointer gives DISP highest priority.
//  - Undefined: fixed priority as above.
//  - The handshake and latency are identical in both builds.
// STRUCTURE
//  - board_pkg: ADDR_W, NUM_CELLS, RD_LAT defaults; requester ids REQ_DISP=0, REQ_PLACE=1, REQ_CNT=2, REQ_NONE=3.
//  - Sub-module req_priority_sel: 3-bit req + priority pointer -> one-hot grant.
//    It is combinational; the round-robin pointer register lives in the parent.
// TESTING
//  1. d_req at addr 0x12 with memory 0x12 = 1
//     -> d_gnt in the same cycle; mem_addr = 0x12 next cycle; d_rvalid with rdata = 1 two cycles after the handshake (RD_LAT = 1).
//  2. d_req, p_req and c_req held continuously, fixed build
//     -> only d_gnt ever asserts; p_gnt = c_gnt = 0 (starvation by design).
//  3. Same as 2 with ARB_ROUND_ROBIN_EN
//     -> grants follow the sequence D, P, C, D, P, C; each requester gets 1 grant per 3 cycles.
//  4. p_req, p_we = 1, p_addr = 0xFF, p_wdata = 1 -> one-cycle mem_wren with mem_addr = 0xFF, mem_data = 1; no p_rvalid.
//  5. clear_start with c_req pending
//     -> 256 consecutive writes of 0 to addresses 0x00..0xFF; c_gnt = 0 throughout.
//     -> clear_done pulses once, then c_gnt is given in the following cycle.
//  6. rst asserted at clear write 100 -> next cycle: ARB, clear_busy = 0, mem_wren = 0, no clear_done.

Source files
------------

// File: rtl/board_pkg.sv
// Shared constants and types for the mine-board memory arbiter.
package board_pkg;

  localparam int ADDR_W    = 8;
  localparam int NUM_CELLS = 256;
  localparam int RD_LAT    = 1;

  typedef enum logic [1:0] {
    REQ_DISP  = 2'd0,
    REQ_PLACE = 2'd1,
    REQ_CNT   = 2'd2,
    REQ_NONE  = 2'd3
  } req_id_t;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_t;

  // The requester after the one just served becomes highest priority.
  function automatic req_id_t next_ptr(input req_id_t id);
    case (id)
      REQ_DISP:  return REQ_PLACE;
      REQ_PLACE: return REQ_CNT;
      default:   return REQ_DISP;
    endcase
  endfunction

  function automatic req_id_t onehot_to_id(input logic [2:0] oh);
    case (oh)
      3'b001:  return REQ_DISP;
      3'b010:  return REQ_PLACE;
      3'b100:  return REQ_CNT;
      default: return REQ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/req_priority_sel.sv
// Combinational one-hot grant select: searches req starting at the
// requester named by ptr, wrapping DISP -> PLACE -> CNT -> DISP.
module req_priority_sel
  import board_pkg::*;
(
  input  logic [2:0] req,
  input  req_id_t    ptr,
  output logic [2:0] gnt
);

  always_comb begin
    logic       found;
    logic [1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 3; k++) begin
      idx = 2'((int'(ptr) + k) % 3);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_mem_arbiter.sv
// Single-port board memory arbiter with board-clear sequencer.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise DISP > PLACE > CNT.
module board_mem_arbiter
  import board_pkg::*;
#(
  parameter int ADDR_W    = board_pkg::ADDR_W,
  parameter int NUM_CELLS = board_pkg::NUM_CELLS,
  parameter int RD_LAT    = board_pkg::RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic              p_wdata,
  output logic              p_gnt,
  output logic              p_rvalid,
  input  logic              c_req,
  input  logic [ADDR_W-1:0] c_addr,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic              rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_data,
  output logic              mem_wren,
  input  logic              mem_q
);

  localparam int PIPE_D = 1 + RD_LAT;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NUM_CELLS - 1);

  arb_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] clr_cnt_reg;
  logic              clear_done_reg;
  logic              grant_en;
  logic              clr_last;
  logic [2:0]        sel_gnt;
  logic [2:0]        gnt;
  req_id_t           sel_ptr;
  logic [ADDR_W-1:0] hs_addr;
  logic              hs_we;
  logic              hs_data;
  req_id_t           hs_tag;
  req_id_t           tag_pipe_reg [PIPE_D];

  assign clr_last = (clr_cnt_reg == LAST_CELL);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_ARB;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_ARB:   if (clear_start) state_next = ST_CLEAR;
      ST_CLEAR: if (clr_last)    state_next = ST_ARB;
      default:  state_next = ST_ARB;
    endcase
  end

  // Output logic; the clear_done cycle carries the final clear write, so
  // grants resume one cycle later.
  always_comb begin
    grant_en   = 1'b0;
    clear_busy = 1'b0;
    case (state_reg)
      ST_ARB:   grant_en   = !clear_start && !clear_done_reg;
      ST_CLEAR: clear_busy = 1'b1;
      default:  grant_en   = 1'b0;
    endcase
  end

`ifdef ARB_ROUND_ROBIN_EN
  req_id_t ptr_reg;
  always_ff @(posedge clk) begin
    if (rst)       ptr_reg <= REQ_DISP;
    else if (|gnt) ptr_reg <= next_ptr(onehot_to_id(gnt));
  end
  assign sel_ptr = ptr_reg;
`else
  assign sel_ptr = REQ_DISP;
`endif

  req_priority_sel u_sel (
    .req (({c_req, p_req, d_req})),
    .ptr (sel_ptr),
    .gnt (sel_gnt)
  );

  assign gnt   = grant_en ? sel_gnt : 3'b000;
  assign d_gnt = gnt[0];
  assign p_gnt = gnt[1];
  assign c_gnt = gnt[2];

  always_comb begin
    hs_addr = '0;
    hs_we   = 1'b0;
    hs_data = 1'b0;
    hs_tag  = REQ_NONE;
    case (gnt)
      3'b001: begin hs_addr = d_addr; hs_tag = REQ_DISP; end
      3'b010: begin
        hs_addr = p_addr;
        hs_we   = p_we;
        hs_data = p_wdata;
        hs_tag  = p_we ? REQ_NONE : REQ_PLACE;
      end
      3'b100: begin hs_addr = c_addr; hs_tag = REQ_CNT; end
      default: hs_tag = REQ_NONE;
    endcase
  end

  // Memory command register: the clear sweep owns the port while in CLEAR.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr <= '0;
      mem_data <= 1'b0;
      mem_wren <= 1'b0;
    end else if (state_reg == ST_CLEAR) begin
      mem_addr <= clr_cnt_reg;
      mem_data <= 1'b0;
      mem_wren <= 1'b1;
    end else if (|gnt) begin
      mem_addr <= hs_addr;
      mem_data <= hs_data;
      mem_wren <= hs_we;
    end else begin
      mem_wren <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state_reg != ST_CLEAR || clr_last) clr_cnt_reg <= '0;
    else                                          clr_cnt_reg <= clr_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) clear_done_reg <= 1'b0;
    else     clear_done_reg <= (state_reg == ST_CLEAR) && clr_last;
  end
  assign clear_done = clear_done_reg;

  // Read tags travel alongside the memory latency so returns stay in order.
  always_ff @(posedge clk) begin
    if (rst) tag_pipe_reg[0] <= REQ_NONE;
    else     tag_pipe_reg[0] <= hs_tag;
  end

  generate
    for (genvar gi = 1; gi < PIPE_D; gi++) begin : g_tag_pipe
      always_ff @(posedge clk) begin
        if (rst) tag_pipe_reg[gi] <= REQ_NONE;
        else     tag_pipe_reg[gi] <= tag_pipe_reg[gi-1];
      end
    end
  endgenerate

  assign d_rvalid = (tag_pipe_reg[PIPE_D-1] == REQ_DISP);
  assign p_rvalid = (tag_pipe_reg[PIPE_D-1] == REQ_PLACE);
  assign c_rvalid = (tag_pipe_reg[PIPE_D-1] == REQ_CNT);
  assign rdata    = mem_q;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Scoreboard bench for board_mem_arbiter with a 256x1 registered-read memory model.
module tb_board_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear_start, clear_busy, clear_done;
  logic       d_req, d_gnt, d_rvalid;
  logic [7:0] d_addr;
  logic       p_req, p_we, p_wdata, p_gnt, p_rvalid;
  logic [7:0] p_addr;
  logic       c_req, c_gnt, c_rvalid;
  logic [7:0] c_addr;
  logic       rdata;
  logic [7:0] mem_addr;
  logic       mem_data, mem_wren, mem_q;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  always #5 clk = ~clk;

  board_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid),
    .c_req(c_req), .c_addr(c_addr), .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .rdata(rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic pattern(input int a);
    logic [7:0] v;
    v = 8'(a);
    if (v == 8'h12) return 1'b1;
    return ^(v ^ (v >> 3));
  endfunction

  // Board memory: one-clock registered read, write on mem_wren.
  logic mem [256];
  bit   mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] = pattern(i);
      mem_init = 1'b1;
    end
    mem_q <= mem[mem_addr];
    if (mem_wren) mem[mem_addr] = mem_data;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected returns pushed at each read handshake.
  typedef struct {
    logic [2:0] vec;
    logic       data;
    int         due;
  } exp_t;
  exp_t sb[$];
  logic ref_mem [256];
  bit   ref_init = 1'b0;

  always @(negedge clk) begin
    logic [2:0] rv;
    logic [2:0] g;
    exp_t       e;
    if (!ref_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = pattern(i);
      ref_init = 1'b1;
    end
    rv = {c_rvalid, p_rvalid, d_rvalid};
    g  = {c_gnt, p_gnt, d_gnt};
    if (rst) begin
      sb.delete();
    end else begin
      check("gnt_onehot", 32'($countones(g) <= 1), 1);
      if (rv != 3'b000) begin
        if (sb.size() == 0) begin
          check("rv_spurious", 32'(rv), 0);
        end else begin
          e = sb.pop_front();
          check("rv_tag", 32'(rv), 32'(e.vec));
          check("rv_data", 32'(rdata), 32'(e.data));
          check("rv_cycle", cyc, e.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        check("rv_missing", 32'(rv), 32'(sb[0].vec));
        void'(sb.pop_front());
      end
      if (d_req && d_gnt) sb.push_back('{3'b001, ref_mem[d_addr], cyc + 2});
      if (p_req && p_gnt && !p_we) sb.push_back('{3'b010, ref_mem[p_addr], cyc + 2});
      if (p_req && p_gnt && p_we) ref_mem[p_addr] = p_wdata;
      if (c_req && c_gnt) sb.push_back('{3'b100, ref_mem[c_addr], cyc + 2});
      if (clear_start && !clear_busy)
        for (int i = 0; i < 256; i++) ref_mem[i] = 1'b0;
    end
  end

  // Called at #1 after a posedge; returns at #1 after the handshake edge.
  task automatic access(input int who, input logic we, input logic [7:0] a, input logic wd);
    bit got;
    got = 1'b0;
    case (who)
      0:       begin d_req = 1'b1; d_addr = a; end
      1:       begin p_req = 1'b1; p_we = we; p_addr = a; p_wdata = wd; end
      default: begin c_req = 1'b1; c_addr = a; end
    endcase
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      got = (who == 0) ? d_gnt : (who == 1) ? p_gnt : c_gnt;
      @(posedge clk);
      #1;
      if (got) break;
    end
    d_req = 1'b0; p_req = 1'b0; c_req = 1'b0;
    if (!got) check("access_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int  pulses;
    bit  found;
    logic [2:0] exp_g;
    rst = 1'b1; clear_start = 1'b0;
    d_req = 1'b0; d_addr = '0;
    p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = 1'b0;
    c_req = 1'b0; c_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'({c_gnt, p_gnt, d_gnt}), 0);
    check("rst_rvalid", 32'({c_rvalid, p_rvalid, d_rvalid}), 0);
    check("rst_busy", 32'(clear_busy), 0);
    check("rst_done", 32'(clear_done), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_data", 32'(mem_data), 0);
    check("rst_mem_wren", 32'(mem_wren), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // All three requesters held continuously
    d_req = 1'b1; d_addr = 8'h01;
    p_req = 1'b1; p_we = 1'b0; p_addr = 8'h02;
    c_req = 1'b1; c_addr = 8'h03;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = 3'(1 << (i % 3));
`else
      exp_g = 3'b001;
`endif
      check("all_req_gnt", 32'({c_gnt, p_gnt, d_gnt}), 32'(exp_g));
      @(posedge clk); #1;
    end
    d_req = 1'b0; p_req = 1'b0; c_req = 1'b0;
    idle(4);

    // Single DISP read of a cell holding a mine
    d_req = 1'b1; d_addr = 8'h12;
    @(negedge clk);
    check("t1_d_gnt", 32'(d_gnt), 1);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    check("t1_mem_addr", 32'(mem_addr), 32'h12);
    check("t1_mem_wren", 32'(mem_wren), 0);
    @(negedge clk);
    check("t1_d_rvalid", 32'(d_rvalid), 1);
    check("t1_rdata", 32'(rdata), 1);
    @(posedge clk); #1;

    // PLACE write: one mem_wren cycle, no read return
    access(1, 1'b1, 8'hFF, 1'b1);
    @(negedge clk);
    check("t4_wren", 32'(mem_wren), 1);
    check("t4_addr", 32'(mem_addr), 32'hFF);
    check("t4_data", 32'(mem_data), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_wren_off", 32'(mem_wren), 0);
    @(posedge clk); #1;

    // Back-to-back mixed reads
    access(1, 1'b0, 8'hFF, 1'b0);
    access(2, 1'b0, 8'h12, 1'b0);
    access(0, 1'b0, 8'h40, 1'b0);
    access(2, 1'b0, 8'h41, 1'b0);
    access(1, 1'b0, 8'h07, 1'b0);
    idle(4);

    // Clear with a CNT request pending
    clear_start = 1'b1; c_req = 1'b1; c_addr = 8'h12;
    @(negedge clk);
    check("t5_gnt_at_start", 32'(c_gnt), 0);
    @(posedge clk); #1;
    clear_start = 1'b0;
    for (int i = 1; i <= 258; i++) begin
      @(negedge clk);
      check("t5_busy", 32'(clear_busy), 32'(i <= 256));
      check("t5_wren", 32'(mem_wren), 32'(i >= 2 && i <= 257));
      if (i >= 2 && i <= 257) begin
        check("t5_addr", 32'(mem_addr), 32'(i - 2));
        check("t5_data", 32'(mem_data), 0);
      end
      check("t5_done", 32'(clear_done), 32'(i == 257));
      check("t5_c_gnt", 32'(c_gnt), 32'(i == 258));
      if (i < 258) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    c_req = 1'b0;
    idle(4);

    // Reset in the middle of a sweep
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (mem_wren && mem_addr == 8'd100) begin found = 1'b1; break; end
    end
    check("t6_reach_100", 32'(found), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_busy", 32'(clear_busy), 0);
    check("t6_wren", 32'(mem_wren), 0);
    check("t6_done", 32'(clear_done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (clear_done) pulses++;
    end
    check("t6_no_done", pulses, 0);
    @(posedge clk); #1;
    access(0, 1'b0, 8'h05, 1'b0);
    idle(4);
    check("sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
